bar_renderer: RTL and testbench

Pixel-generation stage feeding `lcd114`: it consumes the driver's `row`/`column` scan coordinates and returns the RGB565 `pixel` for that position. It draws an 8-channel horizontal bar-graph monitor on the 240x135 panel, with a colour key square and a value bar per channel, plus a per-channel peak-hold marker. Channel values are snapshotted once per frame so that bars never tear mid-scan.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/bar_renderer_peak_tracker.sv | 42 ++++
 rtl/bar_renderer.sv | 104 ++++++++++
 tb/tb_bar_renderer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, palette and helpers for the LCD bar-graph renderer.
// Geometry matches the 240x135 panel driven by lcd114.
package lcd_pkg;

    localparam int LCD_W  = 240;
    localparam int LCD_H  = 135;
    localparam int BAND_H = 16;
    localparam int BAR_X0 = 16;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t PALETTE [8] = '{
        16'hd81f, 16'h029f, 16'h069f, 16'h07fd,
        16'h3fe0, 16'hff40, 16'hfd20, 16'hf800
    };

    localparam rgb565_t COL_BG    = 16'h2104;
    localparam rgb565_t COL_PEAK  = 16'hffff;
    localparam rgb565_t COL_BLACK = 16'h0000;

    // 8-bit value to 0..223 columns
    function automatic logic [10:0] scale_len(input logic [7:0] v);
        logic [10:0] w_prod;
        w_prod = {3'b000, v} * 11'd7;
        return w_prod >> 3;
    endfunction

endpackage

// File: rtl/bar_renderer_peak_tracker.sv
// Per-channel peak-hold with delayed linear decay, updated once per frame.
// The peak never drops below the current snapshot value.
module peak_tracker #(
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY       = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_start,
    input  logic [7:0] value,
    output logic [7:0] peak
);

    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [HW-1:0] r_hold;
    logic [7:0]    r_peak;
    logic [7:0]    w_dec;
    logic [7:0]    w_floor;

    assign w_dec   = (r_peak > 8'(DECAY)) ? r_peak - 8'(DECAY) : 8'd0;
    assign w_floor = (w_dec > value) ? w_dec : value;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_peak <= 8'd0;
            r_hold <= '0;
        end else if (frame_start) begin
            if (value >= r_peak) begin
                r_peak <= value;
                r_hold <= HW'(HOLD_FRAMES);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end else begin
                r_peak <= w_floor;
            end
        end
    end

    assign peak = r_peak;

endmodule

// File: rtl/bar_renderer.sv
// 8-channel horizontal bar-graph pixel generator for the lcd114 scan.
// Values are snapshotted at frame start; 2-cycle coordinate-to-pixel pipeline.
module bar_renderer
    import lcd_pkg::*;
#(
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY       = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] in_vals,
    input  logic [7:0]  row,
    input  logic [7:0]  column,
    output logic [15:0] pixel
);

    logic [7:0]  r_shadow [8];
    logic [7:0]  w_peak   [8];
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [2:0]  r_ch;
    logic [10:0] r_len;
    logic [10:0] r_plen;
    logic        r_fs;
    logic        w_fs;
    logic [2:0]  w_ch;
    logic [10:0] w_len;
    logic [10:0] w_plen;
    logic [10:0] w_col;
    logic [10:0] w_mk0;
    rgb565_t     w_pix;

    assign w_ch = row[6:4];
    assign w_fs = (row == 8'd0) && (column == 8'd0) &&
                  !((r_row == 8'd0) && (r_col == 8'd0));

    for (genvar g = 0; g < 8; g++) begin : g_peak
        peak_tracker #(
            .HOLD_FRAMES(HOLD_FRAMES),
            .DECAY      (DECAY)
        ) u_peak (
            .clk        (clk),
            .resetn     (resetn),
            .frame_start(w_fs),
            .value      (in_vals[8*g +: 8]),
            .peak       (w_peak[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < 8; n++) r_shadow[n] <= 8'd0;
        end else if (w_fs) begin
            for (int n = 0; n < 8; n++) r_shadow[n] <= in_vals[8*n +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row  <= 8'hff;
            r_col  <= 8'hff;
            r_ch   <= 3'd0;
            r_len  <= 11'd0;
            r_plen <= 11'd0;
            r_fs   <= 1'b0;
        end else begin
            r_row  <= row;
            r_col  <= column;
            r_ch   <= w_ch;
            r_len  <= scale_len(r_shadow[w_ch]);
            r_plen <= scale_len(w_peak[w_ch]);
            r_fs   <= w_fs;
        end
    end

    // stage 1 saw the pre-snapshot values on the frame-start cycle
    assign w_len  = r_fs ? scale_len(r_shadow[r_ch]) : r_len;
    assign w_plen = r_fs ? scale_len(w_peak[r_ch]) : r_plen;
    assign w_col  = {3'b000, r_col};
    assign w_mk0  = 11'(BAR_X0) + w_plen;

    always_comb begin
        w_pix = COL_BG;
        if (r_col >= 8'(LCD_W) || r_row >= 8'(LCD_H)) begin
            w_pix = COL_BLACK;
        end else if (r_row[7]) begin
            w_pix = COL_BLACK;
        end else if (r_row[3:0] == 4'(BAND_H - 1)) begin
            w_pix = COL_BLACK;
        end else if (r_col < 8'(BAR_X0)) begin
            w_pix = PALETTE[r_ch];
        end else if (w_col == w_mk0 || w_col == w_mk0 + 11'd1) begin
            w_pix = COL_PEAK;
        end else if (w_col < 11'(BAR_X0) + w_len) begin
            w_pix = PALETTE[r_ch];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pixel <= 16'h0000;
        else         pixel <= w_pix;
    end

endmodule

// File: tb/tb_bar_renderer.sv
// Directed self-checking bench for bar_renderer.
// Table vectors for geometry plus sequences for snapshot, peak and reset.
module tb_bar_renderer;

    logic        clk;
    logic        resetn;
    logic [63:0] in_vals;
    logic [7:0]  row;
    logic [7:0]  column;
    logic [15:0] pixel;

    int total;
    int bad;
    logic [63:0] cur;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  c;
        logic [15:0] px;
    } vec_t;

    vec_t tab[$];

    bar_renderer dut (
        .clk    (clk),
        .resetn (resetn),
        .in_vals(in_vals),
        .row    (row),
        .column (column),
        .pixel  (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_px(input string nm, input logic [7:0] r,
                          input logic [7:0] c, input logic [15:0] exp);
        @(posedge clk); #1;
        row = r;
        column = c;
        @(posedge clk);
        @(posedge clk); #1;
        chk($sformatf("%s(%0d,%0d)", nm, r, c), pixel, exp);
    endtask

    task automatic frame();
        int n;
        n = 0;
        @(posedge clk); #1;
        in_vals = cur;
        row = 8'd0;
        column = 8'd0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            if (dut.r_fs) n++;
        end
        chk("fs_pulse", 16'(n), 16'd1);
        column = 8'd1;
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] c,
                       input logic [15:0] px);
        vec_t v;
        v.r = r;
        v.c = c;
        v.px = px;
        tab.push_back(v);
    endtask

    initial begin
        int p;
        int mc;
        total = 0;
        bad = 0;
        resetn = 1'b0;
        in_vals = 64'd0;
        cur = 64'd0;
        row = 8'd48;
        column = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel", pixel, 16'h0000);
        resetn = 1'b1;
        chk_px("post_rst", 8'd48, 8'd5, 16'h07fd);
        chk_px("post_rst", 8'd48, 8'd16, 16'hffff);
        chk_px("post_rst", 8'd48, 8'd20, 16'h2104);

        // frame A: ch0=128 ch1=0 ch2=40 ch5=100 ch7=10
        cur[7:0]   = 8'd128;
        cur[23:16] = 8'd40;
        cur[47:40] = 8'd100;
        cur[63:56] = 8'd10;
        frame();

        add(8'd0,   8'd16,  16'hd81f);
        add(8'd0,   8'd127, 16'hd81f);
        add(8'd0,   8'd128, 16'hffff);
        add(8'd0,   8'd129, 16'hffff);
        add(8'd0,   8'd130, 16'h2104);
        add(8'd0,   8'd200, 16'h2104);
        add(8'd15,  8'd5,   16'h0000);
        add(8'd15,  8'd100, 16'h0000);
        add(8'd130, 8'd5,   16'h0000);
        add(8'd128, 8'd0,   16'h0000);
        add(8'd0,   8'd240, 16'h0000);
        add(8'd140, 8'd3,   16'h0000);
        add(8'd112, 8'd0,   16'hf800);
        add(8'd112, 8'd23,  16'hf800);
        add(8'd112, 8'd24,  16'hffff);
        add(8'd112, 8'd26,  16'h2104);
        add(8'd16,  8'd15,  16'h029f);
        add(8'd16,  8'd17,  16'hffff);
        add(8'd16,  8'd18,  16'h2104);
        add(8'd32,  8'd50,  16'h069f);
        add(8'd32,  8'd51,  16'hffff);
        add(8'd32,  8'd53,  16'h2104);
        add(8'd46,  8'd20,  16'h069f);
        add(8'd47,  8'd20,  16'h0000);
        add(8'd80,  8'd102, 16'hff40);
        add(8'd80,  8'd103, 16'hffff);
        add(8'd80,  8'd104, 16'hffff);
        add(8'd80,  8'd105, 16'h2104);
        foreach (tab[i]) chk_px($sformatf("vec%0d", i), tab[i].r, tab[i].c,
                                tab[i].px);

        // latency: column 15 -> 16 on ch1
        chk_px("lat_pre", 8'd16, 8'd15, 16'h029f);
        column = 8'd16;
        @(posedge clk); #1;
        chk("lat_edge1", pixel, 16'h029f);
        @(posedge clk); #1;
        chk("lat_edge2", pixel, 16'hffff);

        // live change without frame start must not show
        cur[23:16] = 8'd200;
        cur[47:40] = 8'd0;
        in_vals = cur;
        chk_px("snap_old", 8'd32, 8'd20, 16'h069f);
        chk_px("snap_old", 8'd46, 8'd60, 16'h2104);
        chk_px("snap_old", 8'd32, 8'd51, 16'hffff);
        frame();
        chk_px("snap_new", 8'd40, 8'd190, 16'h069f);
        chk_px("snap_new", 8'd40, 8'd191, 16'hffff);
        chk_px("snap_new", 8'd40, 8'd193, 16'h2104);
        chk_px("hold", 8'd80, 8'd103, 16'hffff);
        chk_px("hold", 8'd80, 8'd20, 16'h2104);

        repeat (29) frame();
        chk_px("hold_end", 8'd80, 8'd103, 16'hffff);
        chk_px("hold_end", 8'd80, 8'd102, 16'h2104);

        for (int k = 1; k <= 51; k++) begin
            frame();
            p = 100 - 2 * k;
            if (p < 0) p = 0;
            mc = 16 + (p * 7) / 8;
            chk_px($sformatf("decay%0d", k), 8'd80, 8'(mc), 16'hffff);
        end
        chk_px("decay_bg", 8'd80, 8'd18, 16'h2104);

        // full-scale bar and clipped marker
        cur[7:0] = 8'd255;
        frame();
        chk_px("max", 8'd0, 8'd237, 16'hd81f);
        chk_px("max", 8'd0, 8'd238, 16'hd81f);
        chk_px("max", 8'd0, 8'd239, 16'hffff);

        // asynchronous reset mid-scan
        chk_px("pre_rst", 8'd0, 8'd50, 16'hd81f);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("async_rst", pixel, 16'h0000);
        @(posedge clk); #1;
        resetn = 1'b1;
        chk_px("rst_mid", 8'd0, 8'd16, 16'hffff);
        chk_px("rst_mid", 8'd0, 8'd17, 16'hffff);
        chk_px("rst_mid", 8'd0, 8'd20, 16'h2104);
        chk_px("rst_mid", 8'd0, 8'd5, 16'hd81f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
